gbuff_stream_reader: RTL

//  Read-side sequencer for the global buffer. On a start command it issues

---
 rtl/gbuff_stream_reader.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/gbuff_stream_reader.sv
// gbuff_stream_reader
//
// Read-side sequencer for the global buffer. A start command issues
// length_i consecutive reads from base_addr_i. It captures the buffer's
// 1-cycle-latency read data into a small output FIFO, and the FIFO presents
// the words as a valid/ready stream toward the PE-array feeder. The block is
// a read-only master, so the buffer write enable is tied low.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous, active-high reset
//   start_i      burst request, only looked at while idle
//   base_addr_i  first buffer address, captured with start_i
//   length_i     word count 0..2**ADDR_BITS, captured with start_i
//   busy_o       high from the accepted start until done_o
//   done_o       single-cycle completion pulse
//   gb_wr_en_o   buffer write enable, always 0
//   gb_index_o   buffer read address
//   gb_data_i    buffer read data, valid one cycle after the address
//   m_valid_o    stream word valid
//   m_ready_i    stream consumer ready
//   m_data_o     stream word (FIFO head)
//   m_last_o     marks the final word of the burst
module gbuff_stream_reader #(
  parameter int ADDR_BITS  = 8,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [ADDR_BITS-1:0] base_addr_i,
  input  logic [ADDR_BITS:0]   length_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 gb_wr_en_o,
  output logic [ADDR_BITS-1:0] gb_index_o,
  input  logic [DATA_BITS-1:0] gb_data_i,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [DATA_BITS-1:0] m_data_o,
  output logic                 m_last_o
);

  localparam int PTR_BITS = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_BITS = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_BITS:0]   DEPTH_W  = (CNT_BITS + 1)'(FIFO_DEPTH);
  localparam logic [PTR_BITS-1:0] PTR_LAST = PTR_BITS'(FIFO_DEPTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]           state;
  logic [ADDR_BITS-1:0] addr;
  logic [ADDR_BITS-1:0] index_hold;
  logic [ADDR_BITS:0]   rem;
  logic                 pending;
  logic                 pending_last;

  logic [DATA_BITS-1:0] fifo_data [FIFO_DEPTH];
  logic                 fifo_last [FIFO_DEPTH];
  logic [PTR_BITS-1:0]  rd_ptr;
  logic [PTR_BITS-1:0]  wr_ptr;
  logic [CNT_BITS-1:0]  fifo_cnt;

  logic                 push;
  logic                 pop;
  logic                 issue;
  logic                 credit;
  logic                 drained;
  logic [CNT_BITS:0]    occupancy;

  function automatic logic [PTR_BITS-1:0] ptr_next(input logic [PTR_BITS-1:0] p);
    if (p == PTR_LAST) return '0;
    return p + PTR_BITS'(1);
  endfunction

  // Issue control and stream handshakes. Credit counts the read already in
  // flight as an occupied slot, and it counts a pop in this cycle as a freed
  // slot. Because of that, a push can never overflow the FIFO, and a
  // 2-entry FIFO still streams one word per cycle.
  always_comb begin
    pop       = m_valid_o & m_ready_i;
    push      = pending;
    occupancy = {1'b0, fifo_cnt} + {{CNT_BITS{1'b0}}, pending}
              - {{CNT_BITS{1'b0}}, pop};
    credit    = (occupancy < DEPTH_W);
    issue     = (state == ST_ISSUE) && (rem != '0) && credit;
    drained   = (state == ST_DRAIN) && !pending && (fifo_cnt == '0);
  end

  // The output-side flags come straight from state, so busy drops in the
  // same cycle that done pulses. The read address holds its last issued
  // value between reads, which keeps the buffer port quiet when a
  // zero-length burst runs.
  always_comb begin
    gb_wr_en_o = 1'b0;
    gb_index_o = issue ? addr : index_hold;
    done_o     = drained;
    busy_o     = (state != ST_IDLE) && !drained;
    m_valid_o  = (fifo_cnt != '0);
    m_data_o   = fifo_data[rd_ptr];
    m_last_o   = fifo_last[rd_ptr] & m_valid_o;
  end

  // This block holds the burst sequencer and the read-pending flag.
  // pending_last records that the read now in flight was the final one, so
  // its word can be tagged when the data is captured one cycle later.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      addr         <= '0;
      rem          <= '0;
      index_hold   <= '0;
      pending      <= 1'b0;
      pending_last <= 1'b0;
    end else begin
      pending      <= issue;
      pending_last <= issue && (rem == (ADDR_BITS + 1)'(1));
      if (issue) begin
        addr       <= addr + ADDR_BITS'(1);
        rem        <= rem - (ADDR_BITS + 1)'(1);
        index_hold <= addr;
      end
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            addr  <= base_addr_i;
            rem   <= length_i;
            state <= (length_i == '0) ? ST_DRAIN : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (issue && (rem == (ADDR_BITS + 1)'(1))) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (drained) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // These are the FIFO pointers and the occupancy count. A push and a pop
  // in the same cycle leave the count unchanged, and this also holds when
  // the FIFO is full.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_BITS'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_BITS'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // This is the FIFO storage. It has no reset because an entry is only
  // read after the same entry has been written.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data[wr_ptr] <= gb_data_i;
      fifo_last[wr_ptr] <= pending_last;
    end
  end

endmodule
